fifo_wr_arbiter: RTL and testbench

- Shares one write port of the packet buffer FIFO among NUM_REQ requesters, e.g. the per-port ingress parsers.
- Arbitration is round-robin with packet lock: once granted, a requester keeps the FIFO until it sends its last beat.
- Respects FIFO full backpressure.
- Forcibly truncates runaway packets after MAX_BEATS accepted beats and flags an error.

---
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares a single packet-buffer FIFO write port among
// NUM_REQ requesters. Round-robin arbitration with packet lock: the winner
// keeps the port until its last beat, or until MAX_BEATS beats have been
// accepted, at which point the packet is cut and trunc_err pulses.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16,
    localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          grant_valid,
    output logic [IDW-1:0]                grant_id,
    output logic                          trunc_err
);

    // Beat counter only has to reach MAX_BEATS-1; release happens on that beat.
    localparam int BCW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;
    logic               trunc_err_q, trunc_err_d;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic               locked;
    logic               holder_valid;
    logic               holder_last;
    logic               transfer;
    logic               at_max;
    logic [IDW-1:0]     rr_next;
    logic               sel_found;
    logic [IDW-1:0]     sel_id;

    assign locked = (state_q == S_LOCKED);

    // Per-requester data slices and ready: only the lock holder is ever ready,
    // and only while the FIFO has room.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign req_ready[gi] = locked && (grant_id_q == IDW'(gi)) && !fifo_full;
    end

    assign holder_valid = req_valid[grant_id_q];
    assign holder_last  = req_last[grant_id_q];
    assign transfer     = holder_valid && req_ready[grant_id_q];
    assign at_max       = (beat_cnt_q == BCW'(MAX_BEATS - 1));

    // Explicit wrap so non-power-of-two requester counts rotate correctly.
    assign rr_next = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int          idx;
        logic [IDW-1:0] idx_w;
        sel_found = 1'b0;
        sel_id    = rr_ptr_q;
        idx       = 0;
        idx_w     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = IDW'(idx);
            if (!sel_found && req_valid[idx_w]) begin
                sel_found = 1'b1;
                sel_id    = idx_w;
            end
        end
    end

    // Next-state: grant from IDLE, count beats and release while LOCKED.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        beat_cnt_d  = beat_cnt_q;
        trunc_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    state_d    = S_LOCKED;
                    grant_id_d = sel_id;
                    beat_cnt_d = '0;
                end
            end
            S_LOCKED: begin
                if (transfer) begin
                    if (holder_last || at_max) begin
                        state_d     = S_IDLE;
                        rr_ptr_d    = rr_next;
                        beat_cnt_d  = '0;
                        // A MAX_BEATS-th beat carrying last is a clean finish.
                        trunc_err_d = at_max && !holder_last;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            beat_cnt_q  <= '0;
            trunc_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            beat_cnt_q  <= beat_cnt_d;
            trunc_err_q <= trunc_err_d;
        end
    end

    assign grant_valid = locked;
    assign grant_id    = grant_id_q;
    assign trunc_err   = trunc_err_q;
    assign fifo_wr_en  = transfer;
    assign fifo_din    = data_arr[grant_id_q];

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter. Requesters are modelled as packet sources
// holding queues of beats. Before each run a transaction-level model turns
// the pending packets into the expected write stream (round-robin order,
// MAX_BEATS chunking, truncation flags), which is then compared beat by beat.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_full = 1'b0;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_din;
    logic            grant_valid;
    logic [1:0]      grant_id;
    logic            trunc_err;

    int checks = 0;
    int errors = 0;

    // Requester packet sources
    logic [31:0] src_data [N][$];
    bit          src_last [N][$];
    int          chunk_cnt [N];

    // Expected write stream
    int          exp_req   [$];
    logic [31:0] exp_data  [$];
    bit          exp_rel   [$];
    bit          exp_trunc [$];
    int          model_ptr = 0;
    int          nchunks   = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .MAX_BEATS (MB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .trunc_err  (trunc_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Transaction-level model: serve pending requesters round-robin, each
    // grant consuming beats up to the packet end or MB beats, whichever first.
    task automatic plan();
        int pos [N];
        int r;
        int cnt;
        bit done;
        bit l;
        bit any;
        exp_req.delete(); exp_data.delete(); exp_rel.delete(); exp_trunc.delete();
        nchunks = 0;
        for (int i = 0; i < N; i++) pos[i] = 0;
        forever begin
            any = 0;
            r = 0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (model_ptr + k) % N;
                if (!any && pos[c] < src_data[c].size()) begin
                    any = 1;
                    r = c;
                end
            end
            if (!any) break;
            cnt = 0;
            done = 0;
            while (!done && pos[r] < src_data[r].size()) begin
                l = src_last[r][pos[r]];
                exp_req.push_back(r);
                exp_data.push_back(src_data[r][pos[r]]);
                pos[r]++;
                cnt++;
                done = l || (cnt == MB);
                exp_rel.push_back(done);
                exp_trunc.push_back(done && !l);
            end
            nchunks++;
            model_ptr = (r + 1) % N;
        end
    endtask

    task automatic add_packet(input int r, input int len, input logic [31:0] base, input bit rnd);
        for (int b = 0; b < len; b++) begin
            src_data[r].push_back(rnd ? $urandom : base + 32'(b));
            src_last[r].push_back(b == len - 1);
        end
    endtask

    // Drive all pending packets through the DUT and check every cycle.
    task automatic run(input string name, input int full_pct, input int gap_pct);
        int widx = 0;
        int cyc = 0;
        int first_wr = -1;
        int last_wr = -1;
        int r;
        bit trunc_next = 0;
        bit bubble_next = 0;
        logic [3:0] exp_rdy;
        plan();
        for (int i = 0; i < N; i++) chunk_cnt[i] = 0;
        while (widx < exp_data.size() && cyc < 4000) begin
            @(negedge clk);
            checks++;
            if (trunc_err !== trunc_next) begin
                errors++;
                $display("FAIL %s trunc_err cyc %0d: got %b want %b", name, cyc, trunc_err, trunc_next);
            end
            if (bubble_next) begin
                checks++;
                if (grant_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s bubble grant_valid cyc %0d: got %b want 0", name, cyc, grant_valid);
                end
            end
            trunc_next = 0;
            bubble_next = 0;
            fifo_full = ($urandom_range(99) < full_pct);
            for (int i = 0; i < N; i++) begin
                if (src_data[i].size() > 0 && !(chunk_cnt[i] > 0 && $urandom_range(99) < gap_pct)) begin
                    req_valid[i] = 1'b1;
                    req_last[i]  = src_last[i][0];
                    req_data[i*DW +: DW] = src_data[i][0];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'($urandom);
                    req_data[i*DW +: DW] = $urandom;
                end
            end
            #1;
            if (fifo_full) begin
                checks++;
                if (fifo_wr_en !== 1'b0 || req_ready !== '0) begin
                    errors++;
                    $display("FAIL %s full_block cyc %0d: got wr_en %b ready %b want 0 0", name, cyc, fifo_wr_en, req_ready);
                end
            end
            if (fifo_wr_en === 1'b1) begin
                r = exp_req[widx];
                exp_rdy = 4'(1 << r);
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                $display("%s: write %0d req %0d data 0x%08h (exp req %0d data 0x%08h)",
                         name, widx, grant_id, fifo_din, r, exp_data[widx]);
                checks++;
                if (fifo_din !== exp_data[widx] || grant_id !== 2'(r)) begin
                    errors++;
                    $display("FAIL %s write %0d: got req %0d data %h want req %0d data %h",
                             name, widx, grant_id, fifo_din, r, exp_data[widx]);
                end
                checks++;
                if (req_ready !== exp_rdy || grant_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s ready %0d: got ready %b gv %b want ready %b gv 1",
                             name, widx, req_ready, grant_valid, exp_rdy);
                end
                if (req_valid[r] && req_ready[r]) begin
                    void'(src_data[r].pop_front());
                    void'(src_last[r].pop_front());
                end
                chunk_cnt[r] = exp_rel[widx] ? 0 : chunk_cnt[r] + 1;
                trunc_next  = exp_trunc[widx];
                bubble_next = exp_rel[widx];
                widx++;
            end else begin
                checks++;
                if ((req_valid & req_ready) !== '0) begin
                    errors++;
                    $display("FAIL %s missing_write cyc %0d: got wr_en 0 want 1 (valid&ready %b)",
                             name, cyc, req_valid & req_ready);
                end
            end
            cyc++;
        end
        checks++;
        if (widx < exp_data.size()) begin
            errors++;
            $display("FAIL %s timeout: got %0d writes want %0d", name, widx, exp_data.size());
        end
        @(negedge clk);
        req_valid = '0;
        req_last = '0;
        fifo_full = 1'b0;
        checks++;
        if (trunc_err !== trunc_next || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s final: got trunc %b gv %b want trunc %b gv 0", name, trunc_err, grant_valid, trunc_next);
        end
        if (full_pct == 0 && gap_pct == 0) begin
            checks++;
            if (first_wr !== 1 || last_wr !== exp_data.size() + nchunks - 1) begin
                errors++;
                $display("FAIL %s timing: got first %0d last %0d want first 1 last %0d",
                         name, first_wr, last_wr, exp_data.size() + nchunks - 1);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (req_ready !== '0 || fifo_wr_en !== 1'b0 || grant_valid !== 1'b0 ||
            trunc_err !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL %s: got ready %b wr %b gv %b te %b gid %0d want all 0",
                     name, req_ready, fifo_wr_en, grant_valid, trunc_err, grant_id);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        req_last = '1;
        fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset_hold");
        req_valid = '0;
        req_last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_release");
        model_ptr = 0;
    endtask

    task automatic test_all_single();
        for (int r = 0; r < N; r++) add_packet(r, 1, 32'hA0 + 32'(r), 0);
        run("all_single", 0, 0);
    endtask

    task automatic test_basic();
        add_packet(2, 3, 32'h20, 0);
        run("basic", 0, 0);
    endtask

    task automatic test_truncation();
        // Ten beats with no last, then a terminating beat: cut after 8.
        for (int b = 0; b < 10; b++) begin
            src_data[0].push_back(32'h100 + 32'(b));
            src_last[0].push_back(1'b0);
        end
        src_data[0].push_back(32'h10A);
        src_last[0].push_back(1'b1);
        run("truncation", 0, 0);
        add_packet(1, 8, 32'h180, 0);
        run("exact_max", 0, 0);
    endtask

    task automatic test_hold();
        add_packet(3, 5, 32'h300, 0);
        add_packet(0, 1, 32'h0F0, 0);
        run("hold", 0, 60);
    endtask

    task automatic test_backpressure();
        add_packet(1, 4, 32'h110, 0);
        run("backpressure", 45, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < N; r++) begin
            int np;
            np = $urandom_range(4, 1);
            for (int p = 0; p < np; p++) add_packet(r, $urandom_range(20, 1), 0, 1);
        end
        run("random", 25, 20);
    endtask

    task automatic test_midpacket_reset();
        add_packet(2, 1, 32'h2F, 0);
        run("pre_reset", 0, 0);
        @(negedge clk);
        req_valid[2] = 1'b1; req_last[2] = 1'b0; req_data[2*DW +: DW] = 32'h20;
        @(negedge clk);
        #1;
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_din !== 32'h20) begin
            errors++;
            $display("FAIL mid_reset first beat: got wr %b din %h want 1 00000020", fifo_wr_en, fifo_din);
        end
        @(negedge clk);
        req_data[2*DW +: DW] = 32'h21;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset_async");
        req_valid = '0;
        req_last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        add_packet(3, 1, 32'hB3, 0);
        add_packet(0, 1, 32'hB0, 0);
        run("post_reset", 0, 0);
    endtask

    initial begin
        for (int r = 0; r < N; r++) begin
            src_data[r].delete();
            src_last[r].delete();
        end
        test_reset();
        test_all_single();
        test_basic();
        test_truncation();
        test_hold();
        test_backpressure();
        test_random();
        test_midpacket_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
